// File: rtl/calc_pkg.sv
// Shared types and widths for the keypad digit encoder: FSM states, key and
// digit widths, and the zero-extension used to present a digit as an operand.
package calc_pkg;

  localparam int DIGIT_W   = 4;
  localparam int NUM_KEYS  = 10;
  localparam int OPERAND_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } kp_state_e;

  function automatic logic [OPERAND_W-1:0] zext_digit(input logic [DIGIT_W-1:0] digit);
    return {{(OPERAND_W - DIGIT_W){1'b0}}, digit};
  endfunction

endpackage

// File: rtl/prio_enc10.sv
// Ten-input priority encoder: the lowest set bit wins, valid_o flags any bit set.
module prio_enc10
  import calc_pkg::*;
(
  input  logic [NUM_KEYS-1:0] vec_i,
  output logic [DIGIT_W-1:0]  idx_o,
  output logic                valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = {DIGIT_W{1'b0}};
    valid_o = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      idx_o   = vec_i[i] ? DIGIT_W'(i) : idx_o;
      valid_o = valid_o | vec_i[i];
    end
  end

endmodule

// File: rtl/keypad_digit_encoder.sv
// Debounced ten-key digit encoder: synchronizes raw keys, debounces press and
// release, and reports the accepted digit with a held level and a new-digit strobe.
module keypad_digit_encoder
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  keys,
  output logic [OPERAND_W-1:0] number,
  output logic [1:0]           pressed
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  kp_state_e           state_q, state_d;
  logic [DIGIT_W-1:0]  num_q, num_d;
  logic                strobe_q, strobe_d;
  logic                held_q, held_d;
  logic [DIGIT_W-1:0]  enc_idx_s;
  logic                enc_valid_s;

  prio_enc10 u_enc (
    .vec_i   (sync2_q),
    .idx_o   (enc_idx_s),
    .valid_o (enc_valid_s)
  );

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {NUM_KEYS{1'b0}};
      sync2_q <= {NUM_KEYS{1'b0}};
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_W'(0);
        if (enc_valid_s) begin
          cap_d   = sync2_q;
          state_d = DEB_PRESS;
        end else begin
          state_d = IDLE;
        end
      end
      DEB_PRESS: begin
        if (sync2_q != cap_q) begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          num_d    = enc_idx_s;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A different nonzero pattern while held is deliberately ignored.
      HELD: begin
        if (!enc_valid_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = CNT_W'(0);
        end else begin
          state_d = HELD;
        end
      end
      DEB_RELEASE: begin
        if (enc_valid_s) begin
          state_d = HELD;
          cnt_d   = CNT_W'(0);
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
    held_d = (state_d == HELD) || (state_d == DEB_RELEASE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cap_q    <= {NUM_KEYS{1'b0}};
      cnt_q    <= CNT_W'(0);
      num_q    <= {DIGIT_W{1'b0}};
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  assign number  = zext_digit(num_q);
  assign pressed = {strobe_q, held_q};

endmodule

// File: tb/tb_keypad_digit_encoder.sv
// Directed bench for keypad_digit_encoder with a four-cycle debounce window.
module tb_keypad_digit_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keys;
  logic [31:0] number;
  logic [1:0]  pressed;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc, strobe_cnt, last_strobe_cyc, dbl_cnt;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  keypad_digit_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .keys    (keys),
    .number  (number),
    .pressed (pressed)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pressed[1] === 1'b1) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        if (prev_strobe) dbl_cnt++;
      end
      prev_strobe = pressed[1];
    end
  endtask

  task automatic clear_mon();
    cyc             = 0;
    strobe_cnt      = 0;
    last_strobe_cyc = -1;
    dbl_cnt         = 0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    keys = 10'h000;
    step(2);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    keys = 10'h3FF;
    step(3);
    tests_run++;
    if (number !== 32'd0) begin
      $display("FAIL reset_number: got %0d expected 0", number); tests_failed++;
    end
    tests_run++;
    if (pressed !== 2'b00) begin
      $display("FAIL reset_pressed: got %b expected 00", pressed); tests_failed++;
    end
    keys = 10'h000;
    rst  = 1'b0;
    clear_mon();
    step(10);
    tests_run++;
    if (pressed !== 2'b00 || strobe_cnt != 0) begin
      $display("FAIL reset_idle: pressed %b strobes %0d expected 00 and 0", pressed, strobe_cnt); tests_failed++;
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    keys = 10'h008;
    clear_mon();
    step(20);
    tests_run++;
    if (strobe_cnt != 1 || last_strobe_cyc != 7) begin
      $display("FAIL clean_strobe: count %0d at cycle %0d expected 1 at 7", strobe_cnt, last_strobe_cyc); tests_failed++;
    end
    tests_run++;
    if (number !== 32'd3 || pressed !== 2'b01) begin
      $display("FAIL clean_held: number %0d pressed %b expected 3 and 01", number, pressed); tests_failed++;
    end
    keys = 10'h000;
    clear_mon();
    step(6);
    tests_run++;
    if (pressed[0] !== 1'b1) begin
      $display("FAIL clean_release_early: pressed0 %b expected 1", pressed[0]); tests_failed++;
    end
    step(1);
    tests_run++;
    if (pressed !== 2'b00 || number !== 32'd3) begin
      $display("FAIL clean_release: pressed %b number %0d expected 00 and 3", pressed, number); tests_failed++;
    end
  endtask

  task automatic test_bounce();
    do_reset();
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 10'h020 : 10'h000;
      if (i == 4) cyc = 0;
      step(2);
    end
    step(18);
    tests_run++;
    if (strobe_cnt != 1 || last_strobe_cyc != 7) begin
      $display("FAIL bounce_strobe: count %0d at cycle %0d expected 1 at 7", strobe_cnt, last_strobe_cyc); tests_failed++;
    end
    tests_run++;
    if (number !== 32'd5) begin
      $display("FAIL bounce_number: got %0d expected 5", number); tests_failed++;
    end
  endtask

  task automatic test_multi_key();
    do_reset();
    keys = 10'h201;
    clear_mon();
    step(12);
    tests_run++;
    if (strobe_cnt != 1 || number !== 32'd0) begin
      $display("FAIL multi_first: strobes %0d number %0d expected 1 and 0", strobe_cnt, number); tests_failed++;
    end
    keys = 10'h200;
    clear_mon();
    step(12);
    tests_run++;
    if (strobe_cnt != 0 || number !== 32'd0 || pressed[0] !== 1'b1) begin
      $display("FAIL multi_switch: strobes %0d number %0d held %b expected 0, 0, 1", strobe_cnt, number, pressed[0]); tests_failed++;
    end
    keys = 10'h000;
    step(10);
    tests_run++;
    if (pressed !== 2'b00) begin
      $display("FAIL multi_release: pressed %b expected 00", pressed); tests_failed++;
    end
  endtask

  task automatic test_release_bounce();
    logic dropped;
    do_reset();
    keys = 10'h008;
    step(12);
    clear_mon();
    dropped = 1'b0;
    keys = 10'h000;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) keys = 10'h008;
      step(1);
      if (pressed[0] !== 1'b1) dropped = 1'b1;
    end
    tests_run++;
    if (dropped !== 1'b0 || strobe_cnt != 0) begin
      $display("FAIL relbounce_held: dropped %b strobes %0d expected 0 and 0", dropped, strobe_cnt); tests_failed++;
    end
    tests_run++;
    if (number !== 32'd3) begin
      $display("FAIL relbounce_number: got %0d expected 3", number); tests_failed++;
    end
    keys = 10'h000;
    step(10);
    tests_run++;
    if (pressed !== 2'b00 || strobe_cnt != 0) begin
      $display("FAIL relbounce_idle: pressed %b strobes %0d expected 00 and 0", pressed, strobe_cnt); tests_failed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keys = 10'h008;
    step(10);
    keys = 10'h000;
    step(10);
    keys = 10'h080;
    step(4);
    clear_mon();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (number !== 32'd0 || pressed !== 2'b00 || strobe_cnt != 0) begin
      $display("FAIL midreset_abort: number %0d pressed %b strobes %0d expected 0, 00, 0", number, pressed, strobe_cnt); tests_failed++;
    end
    rst = 1'b0;
    clear_mon();
    step(6);
    tests_run++;
    if (strobe_cnt != 0) begin
      $display("FAIL midreset_early: strobes %0d expected 0", strobe_cnt); tests_failed++;
    end
    step(6);
    tests_run++;
    if (strobe_cnt != 1 || last_strobe_cyc != 7 || number !== 32'd7) begin
      $display("FAIL midreset_redeb: strobes %0d at %0d number %0d expected 1 at 7 number 7", strobe_cnt, last_strobe_cyc, number); tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    int total;
    do_reset();
    keys = 10'h002;
    clear_mon();
    step(10);
    total = strobe_cnt;
    tests_run++;
    if (strobe_cnt != 1 || number !== 32'd1) begin
      $display("FAIL b2b_first: strobes %0d number %0d expected 1 and 1", strobe_cnt, number); tests_failed++;
    end
    keys = 10'h000;
    step(10);
    keys = 10'h200;
    step(10);
    tests_run++;
    if (strobe_cnt != 2 || number !== 32'd9) begin
      $display("FAIL b2b_second: strobes %0d number %0d expected 2 and 9", strobe_cnt, number); tests_failed++;
    end
    tests_run++;
    if (dbl_cnt != 0 || total != 1) begin
      $display("FAIL b2b_pulse_width: double-high %0d first-phase %0d expected 0 and 1", dbl_cnt, total); tests_failed++;
    end
  endtask

  initial begin
    rst  = 1'b1;
    keys = 10'h000;
    clear_mon();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_release_bounce();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_digit_encoder.md
KEYPAD_DIGIT_ENCODER -- requirements
Module: keypad_digit_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning clock cycles a key pattern must stay stable to count as accepted (10 ms at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port keys, input, 10 bits: raw asynchronous key lines, bit i high = digit key i pushed.
REQ-005 The block SHALL have port number, output, 32 bits: last accepted digit, zero-extended (0..9).
REQ-006 The block SHALL have port pressed, output, 2 bits: bit0 = debounced "key held" level; bit1 = one-cycle "new digit" strobe.

Function
REQ-007 keys SHALL pass through a 2-flop synchronizer before any other use; this adds 2 cycles of latency.
REQ-008 The synchronized key vector SHALL be reduced by a priority encoder: lowest set index wins; all-zero means no key.
REQ-009 The FSM SHALL have four states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
REQ-010 IDLE: a nonzero synced vector SHALL capture the vector, clear the counter, and go to DEB_PRESS.
REQ-011 DEB_PRESS: the counter SHALL increment each cycle the vector equals the captured one.
REQ-012 DEB_PRESS: any vector change SHALL return to IDLE with the counter cleared.
REQ-013 DEB_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 with a stable vector, the FSM SHALL go to HELD.
REQ-014 On the DEB_PRESS to HELD transition, number SHALL load the encoded digit and pressed[1] SHALL pulse high for exactly one cycle.
REQ-015 HELD: pressed[0] SHALL be 1; an all-zero vector SHALL go to DEB_RELEASE with the counter cleared.
REQ-016 HELD: a change to a different nonzero vector SHALL be ignored, so there is no new strobe without a full release.
REQ-017 DEB_RELEASE: after DEBOUNCE_CYCLES consecutive all-zero cycles, the FSM SHALL go to IDLE.
REQ-018 DEB_RELEASE: any nonzero vector SHALL return to HELD with no strobe, filtering release bounce.
REQ-019 pressed[0] SHALL be 1 in HELD and DEB_RELEASE, and 0 in IDLE and DEB_PRESS.
REQ-020 number SHALL hold its value until the next accepted press.
REQ-021 The counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1, and the counter SHALL never wrap.
REQ-022 DEBOUNCE_CYCLES=1 SHALL be legal: acceptance occurs one cycle after entering DEB_PRESS.

Reset
REQ-023 While rst=1 at a clock edge, the state SHALL become IDLE, the counter and captured vector SHALL clear, number SHALL be 0, pressed SHALL be 2'b00, and the synchronizer flops SHALL be 0.
REQ-024 Reset asserted in any state mid-operation SHALL abort it with no strobe emitted.
REQ-025 After reset, a key already held SHALL be treated as a new press and re-debounced.

Structure
REQ-026 A shared package calc_pkg SHALL hold the FSM state typedef, DIGIT_W=4, NUM_KEYS=10, and the operand width 32.
REQ-027 A sub-module prio_enc10 SHALL be used: combinational, 10-bit input to 4-bit index plus valid.
REQ-028 The synchronizer, counter and FSM SHALL stay in the top module.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Clean press: rst pulse, then keys=10'h008 held 20 cycles -> pressed[1] pulses once at cycle 2+1+4 after the edge; number=3; pressed[0]=1 until 4 cycles after release plus sync.
REQ-030 Bounce: keys toggles 10'h020/0 every 2 cycles for 10 cycles, then stable 10'h020 -> exactly one strobe, number=5, occurring 4 stable cycles after the last toggle plus sync.
REQ-031 Multi-key: keys=10'h201 stable -> number=0 (lowest index); switching to 10'h200 while held -> no strobe, number stays 0.
REQ-032 Release bounce: in HELD, keys 0 for 2 cycles then 10'h008 -> back to HELD, no second strobe; then a clean release -> IDLE.
REQ-033 Reset mid-debounce: rst asserted during DEB_PRESS of key 7 -> number=0, pressed=0, no strobe; keys held on through reset release -> strobe with number=7 after a full re-debounce.
REQ-034 Back-to-back: press 1, full release, press 9 -> two strobes, number=1 then 9; pressed[1] never high for 2 consecutive cycles.
